// File: rtl/not_gate_demux_core_if.sv
// Bundles the data, enable, lane-select and result signals of
// not_gate_demux_core. Clock and reset stay outside as plain ports.
// The master side drives the bit to invert plus the capture controls.
// The slave side (the core) returns:
//   - the combinational inversion,
//   - the one-hot lane copy,
//   - the capture-valid strobe,
//   - the high-inversion counter.
interface not_gate_demux_core_if #(
  parameter int N_OUT = 4,
  parameter int CNT_W = 8
);

  localparam int SEL_W = $clog2(N_OUT);

  logic             a;
  logic             en;
  logic [SEL_W-1:0] sel;
  logic             not_o;
  logic [N_OUT-1:0] dmx_o;
  logic             valid_o;
  logic [CNT_W-1:0] cnt_o;

  modport master (
    output a,
    output en,
    output sel,
    input  not_o,
    input  dmx_o,
    input  valid_o,
    input  cnt_o
  );

  modport slave (
    input  a,
    input  en,
    input  sel,
    output not_o,
    output dmx_o,
    output valid_o,
    output cnt_o
  );

endinterface

// File: rtl/not_gate_demux_core.sv
// Single-bit inverter with a registered 1-to-N demultiplexed copy of the
// inverted bit.
//
// The inversion itself is purely combinational and never touched by
// clock or reset. Each enabled cycle captures ~a into the selected lane,
// clears every other lane and pulses valid for one cycle. A saturating
// counter tracks how many captures carried a high inverted bit.
//
// A select that points past the last lane (only reachable when N_OUT is
// not a power of two) blanks the lanes and suppresses valid. It leaves
// the counter alone.
module not_gate_demux_core #(
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT),
  parameter int CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  not_gate_demux_core_if.slave  bus
);

  logic [N_OUT-1:0] r_dmx;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  logic             w_notA;
  logic [SEL_W-1:0] w_sel;
  logic             w_inRange;
  logic             w_cntFull;
  logic [N_OUT-1:0] w_dmxNext;
  logic             w_validNext;
  logic [CNT_W-1:0] w_cntNext;

  assign w_notA    = ~bus.a;
  assign w_sel     = bus.sel;
  assign w_cntFull = &r_cnt;

  // With a power-of-two lane count every select value names a real lane,
  // so the range test collapses to a constant and no comparator is built.
  if ((1 << SEL_W) == N_OUT) begin : g_fullRange
    assign w_inRange = 1'b1;
  end else begin : g_partialRange
    assign w_inRange = (w_sel < SEL_W'(N_OUT));
  end

  // Work out the next lane pattern, valid strobe and counter value.
  // Lanes are rebuilt from zero on each capture so a previous lane never
  // lingers. When idle the lanes hold and valid drops.
  always_comb begin
    w_dmxNext   = r_dmx;
    w_validNext = 1'b0;
    w_cntNext   = r_cnt;
    if (bus.en) begin
      w_dmxNext = '0;
      if (w_inRange) begin
        for (int i = 0; i < N_OUT; i++) begin
          w_dmxNext[i] = (w_sel == SEL_W'(i)) & w_notA;
        end
        w_validNext = 1'b1;
        if (w_notA && !w_cntFull) begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Register the lane copy, valid strobe and counter.
  // Reset wins over any capture on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dmx   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_dmx   <= w_dmxNext;
      r_valid <= w_validNext;
      r_cnt   <= w_cntNext;
    end
  end

  assign bus.not_o   = w_notA;
  assign bus.dmx_o   = r_dmx;
  assign bus.valid_o = r_valid;
  assign bus.cnt_o   = r_cnt;

endmodule

// File: tb/tb_not_gate_demux_core.sv
// Bench for not_gate_demux_core with three instances sharing one stimulus
// stream:
//   - a 4-lane core with an 8-bit counter,
//   - a 4-lane core with a 2-bit counter, to reach saturation quickly,
//   - a 3-lane core, so select value 3 is out of range.
// Expected values come from a lane/count model written with plain
// arithmetic.
module tb_not_gate_demux_core;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  not_gate_demux_core_if #(.N_OUT(4), .CNT_W(8)) ifc0 ();
  not_gate_demux_core_if #(.N_OUT(4), .CNT_W(2)) ifc1 ();
  not_gate_demux_core_if #(.N_OUT(3), .CNT_W(4)) ifc2 ();

  not_gate_demux_core #(.N_OUT(4), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
  not_gate_demux_core #(.N_OUT(4), .CNT_W(2)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));
  not_gate_demux_core #(.N_OUT(3), .CNT_W(4)) dut2 (.clk(clk), .rst(rst), .bus(ifc2.slave));

  int passCount  = 0;
  int checkCount = 0;

  int   nOut[3]   = '{4, 4, 3};
  int   cntMax[3] = '{255, 3, 15};
  int   mDmx[3]   = '{0, 0, 0};
  int   mCnt[3]   = '{0, 0, 0};
  logic mValid[3] = '{1'b0, 1'b0, 1'b0};

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance the reference model by one rising edge for every instance.
  task automatic modelStep(input logic rstV, input logic aV, input logic enV,
                           input int selV);
    for (int k = 0; k < 3; k++) begin
      if (rstV) begin
        mDmx[k]   = 0;
        mValid[k] = 1'b0;
        mCnt[k]   = 0;
      end else if (enV) begin
        if (selV < nOut[k]) begin
          mDmx[k]   = aV ? 0 : (1 << selV);
          mValid[k] = 1'b1;
          if (!aV && mCnt[k] < cntMax[k]) mCnt[k] = mCnt[k] + 1;
        end else begin
          mDmx[k]   = 0;
          mValid[k] = 1'b0;
        end
      end else begin
        mValid[k] = 1'b0;
      end
    end
  endtask

  // Compare one instance's registered outputs with the model.
  task automatic checkInst(input int k, input logic [31:0] dmx,
                           input logic valid, input logic [31:0] cnt);
    checkOutput($sformatf("dmx%0d", k), dmx, 32'(mDmx[k]));
    checkOutput($sformatf("valid%0d", k), {31'd0, valid}, {31'd0, mValid[k]});
    checkOutput($sformatf("cnt%0d", k), cnt, 32'(mCnt[k]));
  endtask

  // Drive one cycle of inputs on the falling edge and check not_o at once.
  // Then let the rising edge happen and check every registered output.
  task automatic applyStimulus(input logic rstV, input logic aV,
                               input logic enV, input int selV);
    @(negedge clk);
    rst      = rstV;
    ifc0.a   = aV;
    ifc0.en  = enV;
    ifc0.sel = 2'(selV);
    ifc1.a   = aV;
    ifc1.en  = enV;
    ifc1.sel = 2'(selV);
    ifc2.a   = aV;
    ifc2.en  = enV;
    ifc2.sel = 2'(selV);
    #1;
    checkOutput("not0", {31'd0, ifc0.not_o}, {31'd0, ~aV});
    checkOutput("not2", {31'd0, ifc2.not_o}, {31'd0, ~aV});
    @(posedge clk);
    modelStep(rstV, aV, enV, selV);
    #1;
    checkInst(0, 32'(ifc0.dmx_o), ifc0.valid_o, 32'(ifc0.cnt_o));
    checkInst(1, 32'(ifc1.dmx_o), ifc1.valid_o, 32'(ifc1.cnt_o));
    checkInst(2, 32'(ifc2.dmx_o), ifc2.valid_o, 32'(ifc2.cnt_o));
  endtask

  initial begin
    int satSeq[5] = '{1, 2, 3, 3, 3};

    ifc0.a   = 1'b0;
    ifc0.en  = 1'b1;
    ifc0.sel = 2'd0;
    ifc1.a   = 1'b0;
    ifc1.en  = 1'b1;
    ifc1.sel = 2'd0;
    ifc2.a   = 1'b0;
    ifc2.en  = 1'b1;
    ifc2.sel = 2'd0;

    // Reset held for two cycles while enable is high.
    applyStimulus(1'b1, 1'b0, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 0);
    checkOutput("rstDmx", 32'(ifc0.dmx_o), 32'd0);
    checkOutput("rstValid", {31'd0, ifc0.valid_o}, 32'd0);
    checkOutput("rstCnt", 32'(ifc0.cnt_o), 32'd0);
    checkOutput("rstNot", {31'd0, ifc0.not_o}, 32'd1);

    // Inverter stream: 0, 1, then random bits with the capture path idle.
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0, 0);
    end

    // Lane routing across all four lanes, then a low inverted bit.
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, s);
      checkOutput("route", 32'(ifc0.dmx_o), 32'(1) << s);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 2);
    checkOutput("routeHigh", 32'(ifc0.dmx_o), 32'd0);

    // Enable gating after a fresh reset.
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 3);
      checkOutput("gateDmx", 32'(ifc0.dmx_o), 32'b0010);
      checkOutput("gateCnt", 32'(ifc0.cnt_o), 32'd1);
    end

    // Counter saturation on the 2-bit counter.
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 0);
      checkOutput("sat", 32'(ifc1.cnt_o), 32'(satSeq[i]));
    end

    // Out-of-range select on the 3-lane core: lanes blank, count unchanged.
    applyStimulus(1'b0, 1'b0, 1'b1, 3);
    checkOutput("oorDmx", 32'(ifc2.dmx_o), 32'd0);
    checkOutput("oorValid", {31'd0, ifc2.valid_o}, 32'd0);
    checkOutput("oorCnt", 32'(ifc2.cnt_o), 32'd5);

    // Random traffic with occasional mid-stream resets.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
